// File: rtl/fir_coeff_loader.sv
// FIR coefficient loader.
// Streams NUM_TAPS signed coefficients into the filter's coefficient array,
// then drives zeros into the filter for NUM_TAPS cycles to clear its delay
// line, then passes upstream samples through to the filter while running.
module fir_coeff_loader #(
    parameter int NUM_TAPS = 71,
    parameter int COEFF_W  = 8,
    parameter int ADDR_W   = 7,
    parameter int X_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               s_valid,
    input  logic [COEFF_W-1:0] s_data,
    output logic               s_ready,
    output logic               coeff_we,
    output logic [ADDR_W-1:0]  coeff_addr,
    output logic [COEFF_W-1:0] coeff_data,
    input  logic [X_W-1:0]     sample_in,
    input  logic               sample_valid,
    output logic [X_W-1:0]     x_n,
    output logic               busy,
    output logic               loaded,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TAPS - 1);
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                coeff_we_q;
    logic [ADDR_W-1:0]   coeff_addr_q;
    logic [COEFF_W-1:0]  coeff_data_q;
    logic [X_W-1:0]      x_n_q;
    logic                loaded_q;
    logic                done_q;
    logic                cnt_last_s;

    // Terminal count shared by the LOAD word count and the FLUSH cycle count.
    always_comb begin
        cnt_last_s = 1'b0;
        if (cnt_q == LAST_IDX) begin
            cnt_last_s = 1'b1;
        end else begin
            cnt_last_s = 1'b0;
        end
    end

    // Loader FSM with registered write port, sample path and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= {ADDR_W{1'b0}};
            coeff_we_q   <= 1'b0;
            coeff_addr_q <= {ADDR_W{1'b0}};
            coeff_data_q <= {COEFF_W{1'b0}};
            x_n_q        <= {X_W{1'b0}};
            loaded_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // Strobes default low; x_n is zero outside RUN.
            coeff_we_q <= 1'b0;
            done_q     <= 1'b0;
            x_n_q      <= {X_W{1'b0}};
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD;
                        cnt_q   <= {ADDR_W{1'b0}};
                    end
                end
                LOAD: begin
                    // Abort beats a simultaneous start and any offered word.
                    if (abort) begin
                        state_q  <= IDLE;
                        cnt_q    <= {ADDR_W{1'b0}};
                        loaded_q <= 1'b0;
                    end else if (s_valid) begin
                        coeff_we_q   <= 1'b1;
                        coeff_addr_q <= cnt_q;
                        coeff_data_q <= s_data;
                        if (cnt_last_s) begin
                            state_q <= FLUSH;
                            cnt_q   <= {ADDR_W{1'b0}};
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                FLUSH: begin
                    if (abort) begin
                        state_q  <= IDLE;
                        cnt_q    <= {ADDR_W{1'b0}};
                        loaded_q <= 1'b0;
                    end else if (cnt_last_s) begin
                        state_q  <= RUN;
                        cnt_q    <= {ADDR_W{1'b0}};
                        done_q   <= 1'b1;
                        loaded_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RUN: begin
                    // A reload invalidates the running set on the same edge.
                    if (start) begin
                        state_q  <= LOAD;
                        cnt_q    <= {ADDR_W{1'b0}};
                        loaded_q <= 1'b0;
                    end else if (sample_valid) begin
                        x_n_q <= sample_in;
                    end else begin
                        x_n_q <= {X_W{1'b0}};
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    cnt_q    <= {ADDR_W{1'b0}};
                    loaded_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready    = (state_q == LOAD);
    assign busy       = (state_q == LOAD) || (state_q == FLUSH);
    assign coeff_we   = coeff_we_q;
    assign coeff_addr = coeff_addr_q;
    assign coeff_data = coeff_data_q;
    assign x_n        = x_n_q;
    assign loaded     = loaded_q;
    assign done       = done_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: randomized loads, gapped
// streams, aborts, reloads, RUN passthrough and asynchronous reset.
module tb_fir_coeff_loader;

    localparam int NT = 71;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, s_valid, sample_valid;
    logic [7:0] s_data;
    logic [3:0] sample_in;
    logic       s_ready, coeff_we, busy, loaded, done;
    logic [6:0] coeff_addr;
    logic [7:0] coeff_data;
    logic [3:0] x_n;

    int n_chk = 0;
    int n_fail = 0;
    int wr_addr_q[$];
    int wr_data_q[$];
    int done_cnt, ready_cnt;
    int exp_c[NT];

    fir_coeff_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
        .sample_in(sample_in), .sample_valid(sample_valid), .x_n(x_n),
        .busy(busy), .loaded(loaded), .done(done)
    );

    always #5 clk = ~clk;

    // Observe write strobes, done pulses and LOAD cycles mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (coeff_we) begin
                wr_addr_q.push_back(int'(coeff_addr));
                wr_data_q.push_back(int'($signed(coeff_data)));
            end
            if (done) done_cnt++;
            if (s_ready) ready_cnt++;
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt  = 0;
        ready_cnt = 0;
    endtask

    // Compare captured writes with the first n words the bench sent.
    task automatic check_writes(input string tag, input int n);
        int bad = 0;
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            if (i >= n || wr_addr_q[i] != i || wr_data_q[i] != exp_c[i]) bad++;
        end
        check_val({tag, "_count"}, wr_addr_q.size(), n);
        check_val({tag, "_bad_entries"}, bad, 0);
    endtask

    // mode 0: continuous k-35; mode 1: valid alternating 1/0; mode 2: random gaps, data and stray starts.
    task automatic do_load(input int mode);
        int acc = 0;
        int cyc = 0;
        int n = 0;
        int nz = 0;
        int seen = 0;
        logic v;
        @(posedge clk); #1;
        clear_mon();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (acc < NT && cyc < 1000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            s_valid = v;
            s_data  = (mode == 0) ? 8'(acc - 35) : 8'($urandom);
            start   = (mode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
            if (v) begin
                exp_c[acc] = int'($signed(s_data));
                acc++;
            end
            if (cyc == 0) begin
                @(negedge clk);
                check_val("load_entry_loaded", int'(loaded), 0);
                check_val("load_entry_ready", int'(s_ready), 1);
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        check_val("load_cycles", ready_cnt, (mode == 1) ? 2 * NT - 1 : cyc);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            if (x_n != 4'd0) nz++;
            n++;
        end
        check_val("flush_cycles", n, NT);
        check_val("flush_xn_nonzero", nz, 0);
        check_val("done_seen", seen, 1);
        check_val("run_loaded", int'(loaded), 1);
        check_val("run_busy", int'(busy), 0);
        check_writes("load_wr", NT);
        @(negedge clk);
        check_val("done_single_pulse", done_cnt, 1);
        check_val("done_low_after", int'(done), 0);
    endtask

    // Drive samples in RUN; each valid sample must appear one cycle later, invalid ones as 0.
    task automatic run_test(input int cycles);
        int prev = 0;
        int cur;
        @(posedge clk); #1;
        for (int i = 0; i < cycles; i++) begin
            if (i == 0) begin
                sample_in = 4'b1000;
                sample_valid = 1'b1;
            end else if (i < 8) begin
                sample_in = 4'($urandom_range(1, 15));
                sample_valid = 1'b0;
            end else begin
                sample_in = 4'($urandom);
                sample_valid = 1'($urandom);
            end
            cur = sample_valid ? int'($signed(sample_in)) : 0;
            @(negedge clk);
            if (i > 0) check_val("run_xn", int'($signed(x_n)), prev);
            prev = cur;
            @(posedge clk); #1;
        end
        sample_valid = 1'b0;
        @(negedge clk);
        check_val("run_xn_last", int'($signed(x_n)), prev);
    endtask

    // Abort after `words` accepted words, with start held alongside abort.
    task automatic abort_test(input int words);
        @(posedge clk); #1;
        clear_mon();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < words; i++) begin
            s_valid = 1'b1;
            s_data = 8'($urandom);
            exp_c[i] = int'($signed(s_data));
            @(posedge clk); #1;
        end
        abort = 1'b1;
        start = 1'b1;
        s_data = 8'($urandom);
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        s_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_writes("abort_wr", words);
        check_val("abort_loaded", int'(loaded), 0);
        check_val("abort_ready", int'(s_ready), 0);
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_done", done_cnt, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 8'd0;
        sample_in = 4'd0; sample_valid = 1'b0;
        clear_mon();
        #12;
        check_val("reset_outputs", int'({s_ready, coeff_we, coeff_addr, coeff_data, x_n, busy, loaded, done}), 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("idle_ready", int'(s_ready), 0);
        check_val("idle_busy", int'(busy), 0);

        do_load(0);
        run_test(20);
        do_load(2);
        run_test(12);
        abort_test(30);
        do_load(1);
        do_load(2);

        // Reset asserted mid-FLUSH, away from any clock edge.
        @(posedge clk); #1;
        clear_mon();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s_valid = 1'b1;
        repeat (NT) begin
            s_data = 8'($urandom);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("midflush_reset_outputs", int'({s_ready, coeff_we, coeff_addr, coeff_data, x_n, busy, loaded, done}), 0);
        #17;
        rst_n = 1'b1;
        clear_mon();
        repeat (NT + 10) @(posedge clk);
        @(negedge clk);
        check_val("post_reset_busy", int'(busy), 0);
        check_val("post_reset_loaded", int'(loaded), 0);
        check_val("post_reset_done", done_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_coeff_loader.md
FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 Parameters SHALL be: NUM_TAPS, 71, tap count; COEFF_W, 8, coefficient width; ADDR_W, 7, coefficient address width; X_W, 4, sample width.
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 start  in  1  request coefficient (re)load.
REQ-005 abort  in  1  cancel a load in progress.
REQ-006 s_valid  in  1  coefficient stream word valid.
REQ-007 s_data  in  COEFF_W  signed coefficient; stream order is tap 0 first.
REQ-008 s_ready  out  1  loader accepts s_data this cycle.
REQ-009 coeff_we  out  1  write strobe to coefficient register array.
REQ-010 coeff_addr  out  ADDR_W  tap index for the write.
REQ-011 coeff_data  out  COEFF_W  coefficient value for the write.
REQ-012 sample_in  in  X_W  signed upstream (upsampled) sample.
REQ-013 sample_valid  in  1  sample_in valid.
REQ-014 x_n  out  X_W  signed sample to FIR filter input.
REQ-015 busy  out  1  high in LOAD or FLUSH.
REQ-016 loaded  out  1  level; a full coefficient set is in place and filter is running.
REQ-017 done  out  1  single-cycle pulse on entry to RUN.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, FLUSH, RUN; one word counter cnt (ADDR_W bits) shared by LOAD and FLUSH.
REQ-019 IDLE: s_ready=0, coeff_we=0, x_n=0; start=1 -> LOAD with cnt=0.
REQ-020 LOAD: s_ready=1 combinationally from state; a word is accepted when s_valid&&s_ready.
REQ-021 Accepted word SHALL produce, on the next cycle, coeff_we=1, coeff_addr=cnt at acceptance, coeff_data=s_data (registered, 1-cycle latency); cnt increments per acceptance.
REQ-022 s_valid low in LOAD SHALL stall with no write and no cnt change; no timeout.
REQ-023 Acceptance with cnt=NUM_TAPS-1 SHALL transition to FLUSH with cnt=0; exactly NUM_TAPS writes per load, addresses 0..NUM_TAPS-1 ascending, no address repeated or skipped.
REQ-024 FLUSH: x_n=0 for exactly NUM_TAPS cycles to clear the filter delay line; then RUN.
REQ-025 Entry to RUN: done=1 for one cycle; loaded=1 held while in RUN.
REQ-026 RUN: x_n registered each cycle = sample_in if sample_valid else 0 (1-cycle latency); in all other states x_n=0.
REQ-027 start in RUN SHALL go to LOAD, cnt=0, loaded=0 in the same edge; start in LOAD or FLUSH SHALL be ignored.
REQ-028 abort in LOAD or FLUSH SHALL go to IDLE, loaded=0, no further writes; a write already registered from the previous acceptance still completes that cycle; abort in IDLE/RUN ignored.
REQ-029 abort and start asserted together: abort wins in LOAD/FLUSH; start wins in IDLE/RUN.
REQ-030 Values SHALL pass unmodified (no sign extension, scaling, or saturation).

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE, cnt=0, and s_ready, coeff_we, coeff_addr, coeff_data, x_n, busy, loaded, done all to 0.
REQ-032 Reset mid-LOAD SHALL leave loaded=0; a fresh start is required, partial array contents are not considered valid.
REQ-033 First state change after rst_n release SHALL occur no earlier than the first rising clk edge with rst_n=1.

Verification
REQ-034 Continuous load: start, s_valid=1 with s_data=k-35 for k=0..70 -> 71 writes, addr 0..70, data -35..35, FLUSH 71 cycles x_n=0, done pulse once, loaded=1.
REQ-035 Gapped stream: s_valid toggled 1/0 -> writes only on accepted words, addresses still contiguous 0..70, load takes 141 cycles.
REQ-036 Abort after 30 words -> exactly 30 writes (addr 0..29), IDLE, loaded=0, s_ready=0, no done.
REQ-037 RUN passthrough: sample_in=-8 valid, then 7 invalid -> x_n=-8 then 0 one cycle later each.
REQ-038 Reload from RUN with start, plus start pulses during LOAD -> loaded drops same edge, single 71-write sequence, extra starts ignored.
REQ-039 rst_n asserted mid-FLUSH, asynchronous to clk -> all outputs 0 immediately, IDLE after release, no done.
